tree_decoder_unit: RTL and testbench
====================================

// Module: tree_decoder_unit
// PURPOSE
//  Binary-to-one-hot decoder with enable, built as a tree of 1:2 decoder nodes.
//  One tree level per select bit: the MSB splits at the root, the LSB at the leaves.
//  Generic selection/enable building block for mux select, register-file write strobes,
//  address decode, etc.
//  Combinational by default; an optional registered-output stage is available.
// PARAMETERS
//  OUTPUT_WIDTH  default 8  number of one-hot outputs, >=1, need not be a power of 2
//  SEL_W (localparam)       $clog2(max(OUTPUT_WIDTH,2)); the select is 1 bit wide even when OUTPUT_WIDTH=1
// PORTS
//  clk_i     in   1             clock, rising edge
//  rst_i     in   1             synchronous, active-high reset
//  enable_i  in   1             decode enable; 0 forces all outputs low
//  select_i  in   SEL_W         binary index of the output to assert
//  out       out  OUTPUT_WIDTH  one-hot decoded output
// BEHAVIOUR
//  - Decode: out = enable_i ? (1 << select_i) : '0, truncated to OUTPUT_WIDTH bits.
//  - Tree structure: level k (k=0 root) consumes select_i[SEL_W-1-k].
//    - Each node: child0 = en & ~s, child1 = en & s.
//    - The root node's enable is enable_i.
//    - Leaves map to out[i] in natural binary order, so out[i] is high iff select_i==i.
//  - Non-power-of-2 OUTPUT_WIDTH: build the full 2^SEL_W-leaf tree and drop leaves >= OUTPUT_WIDTH.
//    select_i >= OUTPUT_WIDTH gives out='0; no error flag.
//  - OUTPUT_WIDTH=1: select_i is 1 bit; select_i=0 -> out=1, select_i=1 -> out=0.
//  - At most one bit of out is high at any time; out is never X for known inputs.
//  - Default build: purely combinational, zero-cycle latency.
//    clk_i/rst_i are unused and must not affect out.
//  - Enable and select take effect in the same evaluation; enable has priority (en=0 -> '0).
// CONFIGURATION
//  TREE_DECODER_REG_OUT_EN defined:
//   - out is registered on the rising edge of clk_i: out <= decode(enable_i, select_i).
//   - Latency is exactly 1 cycle; a new select can be presented every cycle (full throughput).
//   - rst_i=1 at a clock edge -> out <= '0. Reset takes priority over any enable/select value.
//   - Reset asserted mid-operation clears out on the next edge.
//   - The first edge after reset release loads the decode of the inputs sampled at that edge.
//  TREE_DECODER_REG_OUT_EN undefined:
//   - Combinational behaviour exactly as in BEHAVIOUR; no storage elements inferred.
// TESTING
//  1. OUTPUT_WIDTH=8, enable_i=1, sweep select_i 0..7, check after settle
//     -> out==1<<select_i (e.g. sel=5 -> 8'b0010_0000).
//  2. OUTPUT_WIDTH=8, enable_i=0, any select_i (0,3,7) -> out==8'b0; raise enable_i -> correct bit high.
//  3. OUTPUT_WIDTH=5 (SEL_W=3): sel 0..4 -> one-hot; sel 5,6,7 -> out==5'b0.
//  4. OUTPUT_WIDTH=1 (SEL_W=1): sel=0 -> out=1; sel=1 -> out=0.
//  5. REG_OUT_EN, OUTPUT_WIDTH=8:
//     - hold rst_i=1 for 2 edges -> out==0.
//     - Release, sel=2: out==8'h04 one edge later.
//     - Back-to-back sel 2,6 -> 04 then 40 on consecutive edges.
//  6. REG_OUT_EN: with out==8'h40, assert rst_i for one edge -> out==0 on that edge.
//     Deassert with sel=1 -> out==8'h02 on the next edge.

Source files
------------

// File: rtl/tree_decoder_unit.sv
// tree_decoder_unit: binary-to-one-hot decoder with enable, built as a tree
// of 1:2 decoder nodes. The select MSB splits at the root, the LSB at the
// leaves, and leaf i drives out[i] so out[i] is high iff select_i == i.
//
// Leaves at or above OUTPUT_WIDTH are dropped. Any node whose whole subtree
// would only feed dropped leaves is pruned as well, so no logic dangles.
// A select value that is at or above OUTPUT_WIDTH therefore decodes to all zeros.
//
// Optional feature macro: TREE_DECODER_REG_OUT_EN
//   undefined (default): purely combinational, zero-cycle latency; clk_i and
//                        rst_i are not used.
//   defined            : out is registered on the rising edge of clk_i with
//                        a synchronous active-high reset, which clears out.
//                        Latency is one cycle, and a new select can be
//                        accepted on every cycle.
module tree_decoder_unit #(
  parameter int OUTPUT_WIDTH = 8,
  localparam int SEL_W = $clog2(OUTPUT_WIDTH > 1 ? OUTPUT_WIDTH : 2)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [SEL_W-1:0]        select_i,
  output logic [OUTPUT_WIDTH-1:0] out
);

  logic [OUTPUT_WIDTH-1:0] decoded;

  // Level k holds the enables of the nodes at depth k. Node j at level k
  // covers leaves [j*SPAN, (j+1)*SPAN). Only nodes that reach at least one
  // kept leaf are built. Level k (k >= 1) is split from its parent level
  // by select bit SEL_W-k, and that bit is the bit the parent level consumes.
  for (genvar k = 0; k <= SEL_W; k++) begin : g_lvl
    localparam int SPAN  = 1 << (SEL_W - k);
    localparam int NODES = (OUTPUT_WIDTH + SPAN - 1) / SPAN;

    logic [NODES-1:0] en;

    if (k == 0) begin : g_root
      assign en = enable_i;
    end else begin : g_nodes
      for (genvar j = 0; j < NODES; j++) begin : g_node
        if (j % 2 == 0) begin : g_child0
          assign en[j] = g_lvl[k-1].en[j/2] & ~select_i[SEL_W-k];
        end else begin : g_child1
          assign en[j] = g_lvl[k-1].en[j/2] &  select_i[SEL_W-k];
        end
      end
    end
  end

  // The leaf level has exactly OUTPUT_WIDTH nodes, in natural binary order.
  assign decoded = g_lvl[SEL_W].en;

`ifdef TREE_DECODER_REG_OUT_EN
  // Output register: reset clears it; otherwise load this cycle's decode.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out <= '0;
    end else begin
      out <= decoded;
    end
  end
`else
  // Combinational build: the clock and reset have no effect on out.
  logic unused_clk_rst;
  assign unused_clk_rst = clk_i ^ rst_i;
  assign out = decoded;
`endif

endmodule

// File: tb/tb_tree_decoder_unit.sv
// tb_tree_decoder_unit: bench for tree_decoder_unit at OUTPUT_WIDTH 8, 5 and 1.
// All three instances share the same stimulus. The reference decode is plain
// arithmetic: enable && sel < width ? 1 << sel : 0. When the registered
// output is built, the expected value trails the inputs by one edge and is
// zero after any edge where reset was high.
module tb_tree_decoder_unit;

`ifdef TREE_DECODER_REG_OUT_EN
  localparam bit REG_OUT = 1'b1;
`else
  localparam bit REG_OUT = 1'b0;
`endif

  // ---------------- clock / reset block ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] sel;
  logic       running = 1'b0;

  always #5 clk = ~clk;

  logic [7:0] out8;
  logic [4:0] out5;
  logic [0:0] out1;

  tree_decoder_unit #(.OUTPUT_WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .select_i(sel), .out(out8)
  );

  tree_decoder_unit #(.OUTPUT_WIDTH(5)) dut5 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .select_i(sel), .out(out5)
  );

  tree_decoder_unit #(.OUTPUT_WIDTH(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .select_i(sel[0:0]), .out(out1)
  );

  // ---------------- reference model ----------------
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] ref_decode(int width, logic en, int s);
    logic [7:0] v;
    v = 8'd0;
    if (en && s < width) v = 8'(1 << s);
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp8_q[$];
  logic [7:0] exp5_q[$];
  logic [7:0] exp1_q[$];

  task automatic push_expected();
    if (REG_OUT && rst) begin
      exp8_q.push_back(8'd0);
      exp5_q.push_back(8'd0);
      exp1_q.push_back(8'd0);
    end else begin
      exp8_q.push_back(ref_decode(8, enable, int'(sel)));
      exp5_q.push_back(ref_decode(5, enable, int'(sel)));
      exp1_q.push_back(ref_decode(1, enable, int'(sel[0])));
    end
  endtask

  // Registered build: the expectation is captured from the inputs at the edge.
  always @(posedge clk) begin
    if (running && REG_OUT) push_expected();
  end

  // Compare process: the outputs are sampled mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (running) begin
      if (!REG_OUT) push_expected();
      if (exp8_q.size() > 0) check("sb_w8", out8, exp8_q.pop_front());
      if (exp5_q.size() > 0) check("sb_w5", {3'b0, out5}, exp5_q.pop_front());
      if (exp1_q.size() > 0) check("sb_w1", {7'b0, out1}, exp1_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge and are held for one full cycle.
  task automatic apply(input logic r, input logic e, input logic [2:0] s);
    rst    = r;
    enable = e;
    sel    = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    enable  = 1'b0;
    sel     = 3'd0;
    running = 1'b1;
    @(posedge clk);
    #1;

    // Second reset edge, with enable/select active: a registered output
    // stays cleared.
    apply(1'b1, 1'b1, 3'd7);
    check("rst_hold_w8", out8, REG_OUT ? 8'h00 : 8'h80);

    // Release, then back-to-back selects.
    apply(1'b0, 1'b1, 3'd2);
    check("rel_sel2_w8", out8, 8'h04);
    apply(1'b0, 1'b1, 3'd6);
    check("b2b_sel6_w8", out8, 8'h40);

    // Mid-operation reset, then release with sel=1.
    apply(1'b1, 1'b1, 3'd6);
    check("mid_rst_w8", out8, REG_OUT ? 8'h00 : 8'h40);
    apply(1'b0, 1'b1, 3'd1);
    check("post_rst_sel1_w8", out8, 8'h02);

    // Full sweep with enable high.
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, 3'(i));
      check("sweep_w8", out8, 8'(1 << i));
      check("sweep_w5", {3'b0, out5}, (i < 5) ? 8'(1 << i) : 8'h00);
      check("sweep_w1", {7'b0, out1}, (i % 2 == 0) ? 8'h01 : 8'h00);
    end

    // Hand-computed spot values.
    apply(1'b0, 1'b1, 3'd5);
    check("lit_sel5_w8", out8, 8'b0010_0000);
    check("lit_sel5_w5", {3'b0, out5}, 8'h00);
    apply(1'b0, 1'b1, 3'd4);
    check("lit_sel4_w5", {3'b0, out5}, 8'b0001_0000);

    // Enable low forces zero for any select.
    apply(1'b0, 1'b0, 3'd0);
    check("dis_sel0_w8", out8, 8'h00);
    check("dis_sel0_w1", {7'b0, out1}, 8'h00);
    apply(1'b0, 1'b0, 3'd3);
    check("dis_sel3_w8", out8, 8'h00);
    check("dis_sel3_w5", {3'b0, out5}, 8'h00);
    apply(1'b0, 1'b0, 3'd7);
    check("dis_sel7_w8", out8, 8'h00);
    apply(1'b0, 1'b1, 3'd7);
    check("en_rise_sel7_w8", out8, 8'h80);

    // Randomized traffic, checked every cycle by the scoreboard.
    for (int n = 0; n < 400; n++) begin
      apply($urandom_range(15, 0) == 0, $urandom_range(3, 0) != 0, 3'($urandom_range(7, 0)));
    end

    apply(1'b0, 1'b0, 3'd0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
